// File: rtl/reg8_file_pkg.sv
// rtl/reg8_file_pkg.sv - shared sizes and types for the reg8_file register file
package reg8_file_pkg;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    localparam int NREGS  = 8;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [SEL_W-1:0]  sel_t;

endpackage

// File: rtl/reg8_file_cell.sv
// rtl/reg8_file_cell.sv - one storage register with synchronous clear and load
module reg8_file_cell
    import reg8_file_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  logic  wr,
    input  data_t d,
    output data_t q
);

    // Clear wins over a load in the same cycle.
    always_ff @(posedge clk) begin
        if (clr) begin
            q <= '0;
        end else if (wr) begin
            q <= d;
        end
    end

endmodule

// File: rtl/reg8_file.sv
// rtl/reg8_file.sv - NREGS x DATA_W register file, sync write, async read; REG8_FILE_BYPASS_EN adds write-through
module reg8_file
    import reg8_file_pkg::*;
(
    input  logic  clk,
    input  logic  clr,
    input  logic  en,
    input  sel_t  wsel,
    input  sel_t  rsel,
    input  data_t d,
    output data_t q
);

    localparam int IDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

    data_t regs [NREGS];
    logic  rsel_ok;

    for (genvar i = 0; i < NREGS; i++) begin : g_cell
        logic wr;
        assign wr = en & (32'(wsel) == i);

        reg8_file_cell u_cell (
            .clk (clk),
            .clr (clr),
            .wr  (wr),
            .d   (d),
            .q   (regs[i])
        );
    end

    assign rsel_ok = 32'(rsel) < NREGS;

`ifdef REG8_FILE_BYPASS_EN
    logic bypass;
    assign bypass = !clr && en && (wsel == rsel) && rsel_ok;
`endif

    always_comb begin
        q = '0;
        if (rsel_ok) begin
            q = regs[rsel[IDX_W-1:0]];
        end
`ifdef REG8_FILE_BYPASS_EN
        // Forward the pending write so a same-index read sees it before the edge.
        if (bypass) begin
            q = d;
        end
`endif
    end

endmodule

// File: tb/tb_reg8_file.sv
// tb/tb_reg8_file.sv - table-driven self-checking bench for reg8_file
module tb_reg8_file;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       en = 1'b0;
    logic [3:0] wsel = '0;
    logic [3:0] rsel = '0;
    logic [7:0] d = '0;
    logic [7:0] q;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic       clr;
        logic       en;
        logic [3:0] wsel;
        logic [7:0] d;
        logic [3:0] rsel;
        logic [7:0] exp;
    } vec_t;

    vec_t vecs[$];

    reg8_file dut (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .wsel (wsel),
        .rsel (rsel),
        .d    (d),
        .q    (q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic c, input logic e, input logic [3:0] ws,
                       input logic [7:0] dd, input logic [3:0] rs, input logic [7:0] ex);
        vec_t v;
        v.clr = c; v.en = e; v.wsel = ws; v.d = dd; v.rsel = rs; v.exp = ex;
        vecs.push_back(v);
    endtask

    // Apply one edge with the given controls, then read rsel with writes disabled.
    task automatic apply(input vec_t v, input int idx);
        @(negedge clk);
        clr = v.clr; en = v.en; wsel = v.wsel; d = v.d; rsel = v.rsel;
        @(posedge clk);
        #1;
        clr = 1'b0; en = 1'b0;
        #1;
        check($sformatf("vec%0d rsel=%h", idx, v.rsel), q, v.exp);
    endtask

    initial begin
        // clear, then every index reads zero
        add(1'b1, 1'b0, 4'h0, 8'h00, 4'h1, 8'h00);
        for (int i = 0; i < 8; i++) add(1'b0, 1'b0, 4'h0, 8'h00, 4'(i), 8'h00);
        // single write
        add(1'b0, 1'b1, 4'h1, 8'h01, 4'h1, 8'h01);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h2, 8'h00);
        // overwrite of the same register
        add(1'b0, 1'b1, 4'h2, 8'h02, 4'h2, 8'h02);
        add(1'b0, 1'b1, 4'h2, 8'h03, 4'h3, 8'h00);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h2, 8'h03);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h1, 8'h01);
        // en=0 ignored, out-of-range write dropped, out-of-range read is zero
        add(1'b0, 1'b0, 4'h1, 8'hFF, 4'h1, 8'h01);
        add(1'b0, 1'b1, 4'hA, 8'h55, 4'hA, 8'h00);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h2, 8'h03);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 8'h00);
        // boundary indices and rsel=F
        add(1'b0, 1'b1, 4'h7, 8'h77, 4'h7, 8'h77);
        add(1'b0, 1'b1, 4'h0, 8'hC3, 4'h0, 8'hC3);
        add(1'b0, 1'b1, 4'h8, 8'hEE, 4'h7, 8'h77);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'hF, 8'h00);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h8, 8'h00);
        // clear beats a simultaneous write
        add(1'b1, 1'b1, 4'h5, 8'hAA, 4'h5, 8'h00);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h7, 8'h00);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h0, 8'h00);
        add(1'b0, 1'b0, 4'h0, 8'h00, 4'h1, 8'h00);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // Same-index read during a write: old value (or d with bypass) before the edge.
        begin
            vec_t v;
            v.clr = 1'b0; v.en = 1'b1; v.wsel = 4'h4; v.d = 8'h11; v.rsel = 4'h4; v.exp = 8'h11;
            apply(v, 100);
        end
        @(negedge clk);
        en = 1'b1; wsel = 4'h4; rsel = 4'h4; d = 8'h5A;
        #1;
`ifdef REG8_FILE_BYPASS_EN
        check("same-index pre-edge", q, 8'h5A);
`else
        check("same-index pre-edge", q, 8'h11);
`endif
        @(posedge clk);
        #1;
        check("same-index post-edge", q, 8'h5A);
        en = 1'b0;
        #1;
        check("same-index stored", q, 8'h5A);

        // Write to another index must not disturb the read of reg 4.
        @(negedge clk);
        en = 1'b1; wsel = 4'h3; rsel = 4'h4; d = 8'h33;
        #1;
        check("other-index pre-edge", q, 8'h5A);
        @(posedge clk);
        #1;
        en = 1'b0; rsel = 4'h3;
        #1;
        check("other-index stored", q, 8'h33);

        // clr with a same-index write: no forwarding, result is zero.
        @(negedge clk);
        clr = 1'b1; en = 1'b1; wsel = 4'h4; rsel = 4'h4; d = 8'h99;
        #1;
        check("clr same-index pre-edge", q, 8'h5A);
        @(posedge clk);
        #1;
        clr = 1'b0; en = 1'b0;
        #1;
        check("clr same-index post-edge", q, 8'h00);
        rsel = 4'h3;
        #1;
        check("clr reg3", q, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
